// File: rtl/row_bram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : row_bram_access_ctrl
//  Description : Single-port sequencer/arbiter in front of the row buffer
//                BRAM. Round-robin arbitration between the word-wide row
//                loader (writes) and the 5-nibble window reader (reads).
//                Generates the setup-then-strobe BRAM timing and returns
//                each read window as a registered 20-bit result.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_bram_access_ctrl #(
    parameter int WIDTH     = 640,
    parameter int ROW_COUNT = 96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr_req,
    input  logic [6:0]  i_wr_word_idx,
    input  logic [6:0]  i_wr_row,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_ack,
    input  logic        i_rd_req,
    input  logic [9:0]  i_rd_x,
    input  logic [6:0]  i_rd_row,
    output logic        o_rd_ack,
    output logic        o_rd_valid,
    output logic [19:0] o_rd_window,
    output logic        o_req_err,
    output logic        o_busy,
    output logic [9:0]  o_bram_x_pos,
    output logic [6:0]  o_bram_local_y,
    output logic [31:0] o_bram_data_in,
    output logic        o_bram_write,
    output logic        o_bram_read,
    input  logic [19:0] i_bram_nibble_in
);

    localparam int         WORDS   = WIDTH / 8;
    localparam logic [6:0] c_WORDS = 7'(WORDS);
    localparam logic [9:0] c_WIDTH = 10'(WIDTH);
    localparam logic [6:0] c_ROWS  = 7'(ROW_COUNT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_R_SETUP  = 3'd3,
        S_R_LOAD   = 3'd4,
        S_R_OUT    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // r_live stays low for the first cycle after reset release so that no
    // grant is issued while the reset edge is still settling.
    logic        r_live;
    logic        r_rr_last_rd;
    logic [9:0]  r_x_pos;
    logic [6:0]  r_local_y;
    logic [31:0] r_data_in;
    logic [19:0] r_window;
    logic        r_rd_valid;

    logic        w_wr_oor;
    logic        w_rd_oor;
    logic        w_grant_wr;
    logic        w_grant_rd;

    assign w_wr_oor = (i_wr_word_idx >= c_WORDS) || (i_wr_row >= c_ROWS);
    assign w_rd_oor = (i_rd_x >= c_WIDTH) || (i_rd_row >= c_ROWS);

    assign o_bram_x_pos   = r_x_pos;
    assign o_bram_local_y = r_local_y;
    assign o_bram_data_in = r_data_in;
    assign o_rd_window    = r_window;
    assign o_rd_valid     = r_rd_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, next-state and strobe decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_wr   = 1'b0;
        w_grant_rd   = 1'b0;
        o_wr_ack     = 1'b0;
        o_rd_ack     = 1'b0;
        o_req_err    = 1'b0;
        o_bram_write = 1'b0;
        o_bram_read  = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (r_live) begin
                    // Write wins when it is alone or when read was granted last.
                    if (i_wr_req && (!i_rd_req || r_rr_last_rd)) begin
                        w_grant_wr = 1'b1;
                        o_wr_ack   = 1'b1;
                        o_req_err  = w_wr_oor;
                        if (!w_wr_oor) begin
                            w_state_nxt = S_W_SETUP;
                        end
                    end else if (i_rd_req) begin
                        w_grant_rd = 1'b1;
                        o_rd_ack   = 1'b1;
                        o_req_err  = w_rd_oor;
                        if (!w_rd_oor) begin
                            w_state_nxt = S_R_SETUP;
                        end
                    end
                end
            end
            S_W_SETUP: begin
                w_state_nxt = S_W_STROBE;
            end
            S_W_STROBE: begin
                o_bram_write = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            S_R_SETUP: begin
                w_state_nxt = S_R_LOAD;
            end
            S_R_LOAD: begin
                o_bram_read = 1'b1;
                w_state_nxt = S_R_OUT;
            end
            S_R_OUT: begin
                o_bram_read = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Field latching on grant, round-robin history and read-window capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live       <= 1'b0;
            r_rr_last_rd <= 1'b1;
            r_x_pos      <= '0;
            r_local_y    <= '0;
            r_data_in    <= '0;
            r_window     <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_rd_valid <= (r_state == S_R_OUT);
            if (w_grant_wr) begin
                r_rr_last_rd <= 1'b0;
                if (!w_wr_oor) begin
                    r_x_pos   <= {i_wr_word_idx, 3'b000};
                    r_local_y <= i_wr_row;
                    r_data_in <= i_wr_data;
                end
            end
            if (w_grant_rd) begin
                r_rr_last_rd <= 1'b1;
                if (!w_rd_oor) begin
                    r_x_pos   <= i_rd_x;
                    r_local_y <= i_rd_row;
                end
            end
            // The BRAM decodes the window from the live x_pos, which is
            // still held here, so the capture is taken in the last read cycle.
            if (r_state == S_R_OUT) begin
                r_window <= i_bram_nibble_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_row_bram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_row_bram_access_ctrl
//  Description : Self-checking bench for row_bram_access_ctrl with a
//                word-organised BRAM model and a nibble-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_row_bram_access_ctrl;

    localparam int WIDTH = 640;
    localparam int ROWS  = 96;
    localparam int WORDS = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic [6:0]  wr_word_idx;
    logic [6:0]  wr_row;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [9:0]  rd_x;
    logic [6:0]  rd_row;
    logic        rd_ack;
    logic        rd_valid;
    logic [19:0] rd_window;
    logic        req_err;
    logic        busy;
    logic [9:0]  bram_x_pos;
    logic [6:0]  bram_local_y;
    logic [31:0] bram_data_in;
    logic        bram_write;
    logic        bram_read;
    logic [19:0] bram_q;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int n_ws     = 0;
    int n_rs     = 0;
    bit both_seen = 1'b0;
    int last_ack_cyc = 0;

    logic [31:0] bmem [0:ROWS-1][0:WORDS-1];
    bit          mem_ready = 1'b0;
    logic [3:0]  ref_nib [0:ROWS-1][0:WIDTH-1];

    int ack_who [0:7];
    int ack_cyc [0:7];
    int exp_who [0:3] = '{0, 1, 0, 1};
    int exp_off [0:3] = '{1, 4, 8, 11};

    always #5 clk = ~clk;

    row_bram_access_ctrl #(.WIDTH(WIDTH), .ROW_COUNT(ROWS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wr_req         (wr_req),
        .i_wr_word_idx    (wr_word_idx),
        .i_wr_row         (wr_row),
        .i_wr_data        (wr_data),
        .o_wr_ack         (wr_ack),
        .i_rd_req         (rd_req),
        .i_rd_x           (rd_x),
        .i_rd_row         (rd_row),
        .o_rd_ack         (rd_ack),
        .o_rd_valid       (rd_valid),
        .o_rd_window      (rd_window),
        .o_req_err        (req_err),
        .o_busy           (busy),
        .o_bram_x_pos     (bram_x_pos),
        .o_bram_local_y   (bram_local_y),
        .o_bram_data_in   (bram_data_in),
        .o_bram_write     (bram_write),
        .o_bram_read      (bram_read),
        .i_bram_nibble_in (bram_q)
    );

    // BRAM model: 32-bit words, 5-nibble window with zero fill at row edges.
    function automatic logic [19:0] bram_fn(input logic [9:0] xp, input logic [6:0] y);
        logic [19:0] acc;
        int c;
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            c   = int'(xp) + k - 2;
            acc = acc << 4;
            if (c >= 0 && c < WIDTH && int'(y) < ROWS)
                acc[3:0] = bmem[y][c / 8][(c % 8) * 4 +: 4];
        end
        return acc;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int r = 0; r < ROWS; r++)
                for (int w = 0; w < WORDS; w++)
                    bmem[r][w] = '0;
            mem_ready = 1'b1;
        end
        if (bram_write && int'(bram_local_y) < ROWS)
            bmem[bram_local_y][bram_x_pos[9:3]] = bram_data_in;
        bram_q <= bram_fn(bram_x_pos, bram_local_y);
    end

    // Cycle and strobe counters.
    always @(posedge clk) begin
        cyc_cnt++;
        if (bram_write) n_ws++;
        if (bram_read)  n_rs++;
        if (bram_write && bram_read) both_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: row memory as a flat array of nibbles, nibble c of a row
    // lives in word c/8 at nibble position c%8 (low nibble first).
    task automatic ref_write(input int idx, input int row, input logic [31:0] data);
        for (int k = 0; k < 8; k++)
            ref_nib[row][idx * 8 + k] = data[k * 4 +: 4];
    endtask

    function automatic logic [19:0] ref_window(input int x, input int row);
        logic [19:0] acc;
        logic [3:0]  n;
        acc = '0;
        for (int c = x - 2; c <= x + 2; c++) begin
            n = 4'h0;
            if (c >= 0 && c < WIDTH) n = ref_nib[row][c];
            acc = {acc[15:0], n};
        end
        return acc;
    endfunction

    task automatic to_drive();
        @(posedge clk); #1;
    endtask

    task automatic next_sample();
        @(posedge clk); #1; @(negedge clk);
    endtask

    task automatic do_write(input int idx, input int row, input logic [31:0] data);
        bit got;
        int ws0;
        ws0 = n_ws;
        wr_word_idx = 7'(idx); wr_row = 7'(row); wr_data = data; wr_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (wr_ack) begin got = 1'b1; break; end
            to_drive();
        end
        chk("wr_ack_seen", 32'(got), 1);
        if (!got) begin wr_req = 1'b0; return; end
        chk("wr_err", 32'(req_err), 0);
        ref_write(idx, row, data);
        to_drive(); wr_req = 1'b0;
        @(negedge clk);
        chk("w_setup_x", 32'(bram_x_pos), idx * 8);
        chk("w_setup_y", 32'(bram_local_y), row);
        chk("w_setup_data", bram_data_in, data);
        chk("w_setup_write", 32'(bram_write), 0);
        chk("w_setup_busy", 32'(busy), 1);
        next_sample();
        chk("w_strobe_write", 32'(bram_write), 1);
        chk("w_strobe_read", 32'(bram_read), 0);
        chk("w_strobe_x", 32'(bram_x_pos), idx * 8);
        next_sample();
        chk("w_done_busy", 32'(busy), 0);
        chk("w_done_write", 32'(bram_write), 0);
        chk("w_strobe_count", n_ws - ws0, 1);
        to_drive();
    endtask

    task automatic do_read(input int x, input int row, input bit use_lit, input logic [19:0] lit);
        bit got;
        int rs0;
        logic [19:0] exp_w;
        rs0 = n_rs;
        rd_x = 10'(x); rd_row = 7'(row); rd_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rd_ack) begin got = 1'b1; break; end
            to_drive();
        end
        chk("rd_ack_seen", 32'(got), 1);
        if (!got) begin rd_req = 1'b0; return; end
        last_ack_cyc = cyc_cnt;
        chk("rd_err", 32'(req_err), 0);
        exp_w = ref_window(x, row);
        to_drive(); rd_req = 1'b0;
        @(negedge clk);
        chk("r_setup_x", 32'(bram_x_pos), x);
        chk("r_setup_y", 32'(bram_local_y), row);
        chk("r_setup_read", 32'(bram_read), 0);
        chk("r_setup_valid", 32'(rd_valid), 0);
        next_sample();
        chk("r_load_read", 32'(bram_read), 1);
        chk("r_load_write", 32'(bram_write), 0);
        chk("r_load_valid", 32'(rd_valid), 0);
        next_sample();
        chk("r_out_read", 32'(bram_read), 1);
        chk("r_out_x", 32'(bram_x_pos), x);
        chk("r_out_valid", 32'(rd_valid), 0);
        next_sample();
        chk("r_valid", 32'(rd_valid), 1);
        chk("r_window", 32'(rd_window), 32'(exp_w));
        if (use_lit) chk("r_window_lit", 32'(rd_window), 32'(lit));
        chk("r_done_busy", 32'(busy), 0);
        chk("r_done_read", 32'(bram_read), 0);
        chk("r_strobe_count", n_rs - rs0, 2);
        to_drive();
    endtask

    task automatic do_bad(input bit is_rd, input int a, input int row);
        bit got;
        int ws0, rs0;
        ws0 = n_ws; rs0 = n_rs;
        if (is_rd) begin rd_x = 10'(a); rd_row = 7'(row); rd_req = 1'b1; end
        else begin wr_word_idx = 7'(a); wr_row = 7'(row); wr_data = 32'hDEADBEEF; wr_req = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (is_rd ? rd_ack : wr_ack) begin got = 1'b1; break; end
            to_drive();
        end
        chk("oor_ack_seen", 32'(got), 1);
        if (!got) begin rd_req = 1'b0; wr_req = 1'b0; return; end
        chk("oor_err", 32'(req_err), 1);
        chk("oor_busy_grant", 32'(busy), 0);
        to_drive(); rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        chk("oor_busy_after", 32'(busy), 0);
        chk("oor_err_after", 32'(req_err), 0);
        next_sample();
        chk("oor_busy_after2", 32'(busy), 0);
        chk("oor_no_write", n_ws - ws0, 0);
        chk("oor_no_read", n_rs - rs0, 0);
        to_drive();
    endtask

    initial begin
        int rel, n_acks, n_valid, sel, a, b;
        bit got;

        rst_n = 1'b0;
        wr_req = 1'b0; wr_word_idx = '0; wr_row = '0; wr_data = '0;
        rd_req = 1'b0; rd_x = '0; rd_row = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < WIDTH; c++)
                ref_nib[r][c] = 4'h0;

        // Reset state with both requesters already pending.
        repeat (2) @(posedge clk);
        #1;
        wr_word_idx = 7'd10; wr_row = 7'd5; wr_data = 32'hCAFEF00D; wr_req = 1'b1;
        rd_x = 10'd83; rd_row = 7'd5; rd_req = 1'b1;
        @(negedge clk);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        chk("rst_rd_ack", 32'(rd_ack), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_window", 32'(rd_window), 0);
        chk("rst_req_err", 32'(req_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bram_x", 32'(bram_x_pos), 0);
        chk("rst_bram_y", 32'(bram_local_y), 0);
        chk("rst_bram_data", bram_data_in, 0);
        chk("rst_bram_wr", 32'(bram_write), 0);
        chk("rst_bram_rd", 32'(bram_read), 0);

        // Round-robin with both requests held high from reset release.
        to_drive();
        rel = cyc_cnt;
        rst_n = 1'b1;
        n_acks = 0; n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                ack_who[n_acks] = 0; ack_cyc[n_acks] = cyc_cnt; n_acks++;
                ref_write(10, 5, 32'hCAFEF00D);
            end
            if (rd_ack) begin
                ack_who[n_acks] = 1; ack_cyc[n_acks] = cyc_cnt; n_acks++;
            end
            if (rd_valid) begin
                n_valid++;
                chk("arb_window", 32'(rd_window), 32'(ref_window(83, 5)));
            end
            if (n_acks >= 4) break;
            to_drive();
        end
        chk("arb_ack_count", n_acks, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_acks) begin
                chk("arb_order", ack_who[i], exp_who[i]);
                chk("arb_ack_cycle", ack_cyc[i] - rel, exp_off[i]);
            end
        end
        to_drive();
        wr_req = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                n_valid++;
                chk("arb_window", 32'(rd_window), 32'(ref_window(83, 5)));
            end
            to_drive();
        end
        chk("arb_valid_count", n_valid, 2);

        // Directed windows, including row edges and a word-straddling window.
        do_write(5, 3, 32'h76543210);
        do_read(42, 3, 1'b1, 20'h01234);
        do_write(0, 3, 32'h76543210);
        do_write(1, 3, 32'hFEDCBA98);
        do_read(0, 3, 1'b1, 20'h00012);
        do_read(7, 3, 1'b1, 20'h56789);
        do_write(79, 3, 32'h89ABCDEF);
        do_read(639, 3, 1'b1, 20'hA9800);

        // Out-of-range requests at the first illegal value.
        do_bad(1'b0, 80, 3);
        do_bad(1'b1, 640, 3);
        do_bad(1'b1, 10, 96);

        // Reset pulse while a read is in its load phase.
        rd_x = 10'd83; rd_row = 7'd5; rd_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rd_ack) begin got = 1'b1; break; end
            to_drive();
        end
        chk("rl_ack_seen", 32'(got), 1);
        to_drive(); rd_req = 1'b0;
        @(negedge clk);
        next_sample();
        chk("rl_read_high", 32'(bram_read), 1);
        #1;
        rst_n = 1'b0;
        rd_x = 10'd42; rd_row = 7'd3; rd_req = 1'b1;
        #1;
        chk("rl_rst_read", 32'(bram_read), 0);
        chk("rl_rst_busy", 32'(busy), 0);
        chk("rl_rst_x", 32'(bram_x_pos), 0);
        chk("rl_rst_y", 32'(bram_local_y), 0);
        chk("rl_rst_window", 32'(rd_window), 0);
        chk("rl_rst_ack", 32'(rd_ack), 0);
        for (int i = 0; i < 2; i++) begin
            next_sample();
            chk("rl_rst_valid", 32'(rd_valid), 0);
            chk("rl_rst_ack_hold", 32'(rd_ack), 0);
        end
        to_drive();
        rel = cyc_cnt;
        rst_n = 1'b1;
        do_read(42, 3, 1'b1, 20'h01234);
        chk("rl_post_rst_ack_cycle", last_ack_cyc - rel, 1);

        // Randomized mix of writes, reads and illegal requests.
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                if ($urandom_range(0, 1) == 1) do_bad(1'b0, int'($urandom_range(80, 127)), int'($urandom_range(0, 2)));
                else do_bad(1'b0, int'($urandom_range(0, 79)), int'($urandom_range(96, 127)));
            end else if (sel == 1) begin
                if ($urandom_range(0, 1) == 1) do_bad(1'b1, int'($urandom_range(640, 1023)), int'($urandom_range(0, 2)));
                else do_bad(1'b1, int'($urandom_range(0, 639)), int'($urandom_range(96, 127)));
            end else if (sel < 6) begin
                a = ($urandom_range(0, 3) == 0) ? 79 : int'($urandom_range(0, 11));
                b = int'($urandom_range(0, 2));
                do_write(a, b, $urandom);
            end else begin
                a = ($urandom_range(0, 4) == 0) ? 639 - int'($urandom_range(0, 2)) : int'($urandom_range(0, 95));
                b = int'($urandom_range(0, 2));
                do_read(a, b, 1'b0, 20'h0);
            end
        end

        chk("never_read_and_write", 32'(both_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
